// File: rtl/multirate_v2_div_22s_6ns_16_seq.sv
// Sequential signed/unsigned restoring divider: one quotient bit per clock,
// saturated signed quotient, dividend-signed remainder, start/done handshake.
module multirate_v2_div_22s_6ns_16_seq #(
  parameter int din0_WIDTH = 22,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quotient,
  output logic [din1_WIDTH:0]   remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(din0_WIDTH + 1);
  localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
  localparam logic [din0_WIDTH-1:0] POS_LIM = din0_WIDTH'(2**(dout_WIDTH-1) - 1);
  localparam logic [din0_WIDTH-1:0] NEG_LIM = din0_WIDTH'(2**(dout_WIDTH-1));

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t                r_state, w_next;
  // Dividend magnitude and quotient share one shift register: magnitude
  // bits leave at the top while quotient bits enter at the bottom.
  logic [din0_WIDTH-1:0] r_mag;
  logic [din1_WIDTH:0]   r_rem;
  logic [din1_WIDTH-1:0] r_div;
  logic                  r_neg;
  logic                  r_dz;
  logic [CW-1:0]         r_cnt;

  logic                  w_accept;
  logic [din0_WIDTH-1:0] w_abs;
  logic [din1_WIDTH:0]   w_rem_sh;
  logic                  w_ge;
  logic [din1_WIDTH:0]   w_rem_nx;
  logic [dout_WIDTH-1:0] w_q;
  logic [din1_WIDTH:0]   w_r;
  logic                  w_ovf;

  // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits.
  assign w_abs    = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_rem_sh = {r_rem[din1_WIDTH-1:0], r_mag[din0_WIDTH-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_div};
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(1)) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_q   = '0;
    w_r   = r_neg ? (~r_rem + 1'b1) : r_rem;
    w_ovf = 1'b0;
    if (r_dz) begin
      w_q = r_neg ? Q_MIN : Q_MAX;
      w_r = '0;
    end else if (!r_neg) begin
      if (r_mag > POS_LIM) begin
        w_q   = Q_MAX;
        w_ovf = 1'b1;
      end else begin
        w_q = r_mag[dout_WIDTH-1:0];
      end
    end else begin
      if (r_mag > NEG_LIM) begin
        w_q   = Q_MIN;
        w_ovf = 1'b1;
      end else begin
        w_q = ~r_mag[dout_WIDTH-1:0] + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= S_IDLE;
      r_mag       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_neg       <= 1'b0;
      r_dz        <= 1'b0;
      r_cnt       <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      done    <= 1'b0;
      if (w_accept) begin
        r_mag <= w_abs;
        r_rem <= '0;
        r_div <= din1;
        r_neg <= din0[din0_WIDTH-1];
        r_dz  <= (din1 == '0);
        r_cnt <= CW'(din0_WIDTH);
        ready <= 1'b0;
      end
      if (r_state == S_CALC) begin
        r_mag <= {r_mag[din0_WIDTH-2:0], w_ge};
        r_rem <= w_rem_nx;
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == S_FIN) begin
        quotient    <= w_q;
        remainder   <= w_r;
        overflow    <= w_ovf;
        div_by_zero <= r_dz;
        done        <= 1'b1;
        ready       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multirate_v2_div_22s_6ns_16_seq.sv
// Randomized + directed bench for the sequential divider, checked against
// a plain-arithmetic reference model (truncating divide, then saturate).
module tb_multirate_v2_div_22s_6ns_16_seq;
  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        start  = 1'b0;
  logic [21:0] din0   = '0;
  logic [5:0]  din1   = '0;
  logic        ready, done, overflow, div_by_zero;
  logic [15:0] quotient;
  logic [6:0]  remainder;

  int n_chk  = 0;
  int n_fail = 0;

  multirate_v2_div_22s_6ns_16_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .din0(din0), .din1(din1),
    .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int a, input int b, output int q,
                                output int r, output int ov, output int dz);
    q = 0; r = 0; ov = 0; dz = 0;
    if (b == 0) begin
      q  = (a >= 0) ? 32767 : -32768;
      dz = 1;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 32767)  begin q = 32767;  ov = 1; end
      if (q < -32768) begin q = -32768; ov = 1; end
    end
  endfunction

  // Present operands and let the next rising edge accept them.
  task automatic launch(input int a, input int b);
    @(negedge ap_clk);
    din0  = 22'(a);
    din1  = 6'(b);
    start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    din0  = 22'($urandom);
    din1  = 6'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge ap_clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic check_res(input string tag, input int a, input int b);
    int q, r, ov, dz;
    model(a, b, q, r, ov, dz);
    chk({tag, ".q"},   longint'($signed(quotient)),  q);
    chk({tag, ".r"},   longint'($signed(remainder)), r);
    chk({tag, ".ovf"}, overflow,    ov);
    chk({tag, ".dz"},  div_by_zero, dz);
    chk({tag, ".rdy"}, ready, 1);
  endtask

  task automatic do_op(input string tag, input int a, input int b);
    int lat;
    launch(a, b);
    chk({tag, ".busy"}, ready, 0);
    wait_done(lat);
    chk({tag, ".lat"}, lat, 23);
    check_res(tag, a, b);
    @(posedge ap_clk); #1;
    chk({tag, ".pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int a, b;
    logic signed [21:0] ra;

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst.ready", ready, 1);
    chk("rst.done",  done, 0);
    chk("rst.q",     quotient, 0);
    chk("rst.r",     remainder, 0);
    chk("rst.ovf",   overflow, 0);
    chk("rst.dz",    div_by_zero, 0);
    @(negedge ap_clk) ap_rst = 1'b0;

    do_op("p1000_7",  1000, 7);
    do_op("m1000_7", -1000, 7);
    do_op("min_1",   -2097152, 1);
    do_op("sat_pos",  300000, 5);
    do_op("edge_neg", -163840, 5);
    do_op("edge_pos",  163835, 5);
    do_op("m5_0",     -5, 0);
    do_op("p5_0",      5, 0);
    do_op("max_63",    2097151, 63);
    do_op("zero_9",    0, 9);

    // Start pulse during CALC is ignored; start in done cycle is taken.
    launch(1000, 7);
    @(negedge ap_clk);
    din0 = 22'(99); din1 = 6'(2); start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    chk("hs.ignored", ready, 0);
    wait_done(lat);
    chk("hs.lat1", lat, 22);
    check_res("hs.first", 1000, 7);
    din0 = 22'(63); din1 = 6'(63); start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    chk("hs.b2b_done", done, 0);
    chk("hs.b2b_busy", ready, 0);
    wait_done(lat);
    chk("hs.lat2", lat, 23);
    check_res("hs.second", 63, 63);

    // Reset mid-CALC aborts, clears outputs, and produces no done.
    launch(-1000, 7);
    repeat (9) @(posedge ap_clk);
    @(negedge ap_clk) begin ap_rst = 1'b1; start = 1'b1; din0 = 22'(77); din1 = 6'(3); end
    @(posedge ap_clk); #1;
    chk("ab.ready", ready, 1);
    chk("ab.done",  done, 0);
    chk("ab.q",     quotient, 0);
    chk("ab.r",     remainder, 0);
    chk("ab.ovf",   overflow, 0);
    chk("ab.dz",    div_by_zero, 0);
    ap_rst = 1'b0; start = 1'b0;
    wait_done(lat);
    chk("ab.no_done", lat, -1);
    do_op("p50_3", 50, 3);

    for (int i = 0; i < 40; i++) begin
      ra = 22'($urandom);
      case (i % 4)
        0: a = int'(ra);
        1: a = int'(ra) >>> 6;
        2: a = $urandom_range(0, 400000) - 200000;
        default: a = int'(ra) >>> 12;
      endcase
      b = (i % 10 == 9) ? 0 : $urandom_range(1, 63);
      do_op("rnd", a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
